// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory loader: default widths,
// bytes per word and the loader state encoding.
package imem_pkg;

  localparam int unsigned IMEM_ADDR_W    = 8;
  localparam int unsigned IMEM_DATA_W    = 32;
  localparam int unsigned IMEM_BYTE_W    = 8;
  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned IDX_W          = 2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_WRITE   = 2'd2,
    ST_DONE    = 2'd3
  } loader_state_e;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Byte packer: shifts accepted bytes into a word register, MSB byte first,
// and tracks how many bytes of the current word have arrived.
//   clk, reset    : clock, async active-high reset
//   clr           : synchronous clear of index and shift register
//   push, data    : accept one byte this cycle
//   idx           : bytes already held for the current word (0-3)
//   word          : shift register contents
//   word_next_c   : word as it will look once data is shifted in
//   word_full_c   : this push delivers the last byte of a word
module byte_packer
  import imem_pkg::*;
#(
  parameter int unsigned DATA_W = IMEM_DATA_W,
  parameter int unsigned BYTE_W = IMEM_BYTE_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              push,
  input  logic [BYTE_W-1:0] data,
  output logic [IDX_W-1:0]  idx,
  output logic [DATA_W-1:0] word,
  output logic [DATA_W-1:0] word_next_c,
  output logic              word_full_c
);

  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;

  assign word_next_c = {shreg_q[DATA_W-BYTE_W-1:0], data};
  assign word_full_c = push && (idx_q == IDX_W'(BYTES_PER_WORD - 1));
  assign idx         = idx_q;
  assign word        = shreg_q;

  // Next index/shift value; the index wraps to 0 after the 4th byte.
  always_comb begin
    idx_d   = idx_q;
    shreg_d = shreg_q;
    if (clr) begin
      idx_d   = '0;
      shreg_d = '0;
    end else if (push) begin
      idx_d   = idx_q + IDX_W'(1);
      shreg_d = word_next_c;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_q   <= '0;
      shreg_q <= '0;
    end else begin
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory loader: packs a valid/ready byte stream into 32-bit
// words and writes them to consecutive word addresses from 0, keeping a
// word count, XOR checksum and done/error flags for board display.
//   clk, reset            : clock, async active-high reset
//   start, finish         : session control pulses
//   byte_valid/data/ready : byte input handshake
//   wr_en/addr/data       : one-cycle memory write strobe and payload
//   word_count, checksum  : session statistics
//   busy, done            : session status
//   partial_err           : finish with 1-3 bytes pending
//   overflow_err          : byte offered after the last address was written
module imem_loader
  import imem_pkg::*;
#(
  parameter int unsigned ADDR_W = IMEM_ADDR_W,
  parameter int unsigned DATA_W = IMEM_DATA_W,
  parameter int unsigned BYTE_W = IMEM_BYTE_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              finish,
  input  logic              byte_valid,
  input  logic [BYTE_W-1:0] byte_data,
  output logic              byte_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic [ADDR_W:0]   word_count,
  output logic [DATA_W-1:0] checksum,
  output logic              busy,
  output logic              done,
  output logic              partial_err,
  output logic              overflow_err
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};
  localparam logic [CNT_W-1:0]  MAX_COUNT = CNT_W'(1) << ADDR_W;

  loader_state_e     state_q, state_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic [CNT_W-1:0]  word_count_q, word_count_d;
  logic [DATA_W-1:0] checksum_q, checksum_d;
  logic              byte_ready_q, byte_ready_d;
  logic              wr_en_q, wr_en_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              partial_err_q, partial_err_d;
  logic              overflow_err_q, overflow_err_d;
  logic              full_q, full_d;
  logic              finish_pend_q, finish_pend_d;

  logic              accept_c;
  logic              pk_clr_c;
  logic [IDX_W-1:0]  pk_idx;
  logic [DATA_W-1:0] pk_word;
  logic [DATA_W-1:0] pk_word_next_c;
  logic              pk_word_full_c;

  assign accept_c = (state_q == ST_COLLECT) && byte_ready_q && byte_valid;

  byte_packer #(
    .DATA_W (DATA_W),
    .BYTE_W (BYTE_W)
  ) u_packer (
    .clk         (clk),
    .reset       (reset),
    .clr         (pk_clr_c),
    .push        (accept_c),
    .data        (byte_data),
    .idx         (pk_idx),
    .word        (pk_word),
    .word_next_c (pk_word_next_c),
    .word_full_c (pk_word_full_c)
  );

  // Session control; start overrides everything else in every state.
  always_comb begin
    state_d        = state_q;
    wr_addr_d      = wr_addr_q;
    wr_data_d      = wr_data_q;
    word_count_d   = word_count_q;
    checksum_d     = checksum_q;
    partial_err_d  = partial_err_q;
    overflow_err_d = overflow_err_q;
    full_d         = full_q;
    finish_pend_d  = finish_pend_q;
    pk_clr_c       = 1'b0;

    if (start) begin
      state_d        = ST_COLLECT;
      wr_addr_d      = '0;
      word_count_d   = '0;
      checksum_d     = '0;
      partial_err_d  = 1'b0;
      overflow_err_d = 1'b0;
      full_d         = 1'b0;
      finish_pend_d  = 1'b0;
      pk_clr_c       = 1'b1;
    end else begin
      case (state_q)
        ST_COLLECT: begin
          if (full_q) begin
            // Memory is full: any offered byte is an overflow.
            if (byte_valid) begin
              overflow_err_d = 1'b1;
              state_d        = ST_DONE;
            end else if (finish) begin
              state_d = ST_DONE;
            end
          end else if (pk_word_full_c) begin
            state_d       = ST_WRITE;
            wr_data_d     = pk_word_next_c;
            finish_pend_d = finish;
          end else if (finish) begin
            // Bytes held or absorbed this cycle cannot form a word.
            partial_err_d = (pk_idx != '0) || accept_c;
            state_d       = ST_DONE;
          end
        end
        ST_WRITE: begin
          word_count_d = (word_count_q == MAX_COUNT) ? word_count_q
                                                     : word_count_q + CNT_W'(1);
          checksum_d   = checksum_q ^ pk_word;
          pk_clr_c     = 1'b1;
          if (wr_addr_q != LAST_ADDR) begin
            wr_addr_d = wr_addr_q + ADDR_W'(1);
          end
          if (finish_pend_q || finish) begin
            finish_pend_d = 1'b0;
            state_d       = ST_DONE;
          end else begin
            full_d  = (wr_addr_q == LAST_ADDR);
            state_d = ST_COLLECT;
          end
        end
        default: ;
      endcase
    end

    byte_ready_d = (state_d == ST_COLLECT) && !full_d;
    wr_en_d      = (state_d == ST_WRITE);
    busy_d       = (state_d == ST_COLLECT) || (state_d == ST_WRITE);
    done_d       = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      wr_addr_q      <= '0;
      wr_data_q      <= '0;
      word_count_q   <= '0;
      checksum_q     <= '0;
      byte_ready_q   <= 1'b0;
      wr_en_q        <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      partial_err_q  <= 1'b0;
      overflow_err_q <= 1'b0;
      full_q         <= 1'b0;
      finish_pend_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      wr_addr_q      <= wr_addr_d;
      wr_data_q      <= wr_data_d;
      word_count_q   <= word_count_d;
      checksum_q     <= checksum_d;
      byte_ready_q   <= byte_ready_d;
      wr_en_q        <= wr_en_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      partial_err_q  <= partial_err_d;
      overflow_err_q <= overflow_err_d;
      full_q         <= full_d;
      finish_pend_q  <= finish_pend_d;
    end
  end

  assign byte_ready   = byte_ready_q;
  assign wr_en        = wr_en_q;
  assign wr_addr      = wr_addr_q;
  assign wr_data      = wr_data_q;
  assign word_count   = word_count_q;
  assign checksum     = checksum_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign partial_err  = partial_err_q;
  assign overflow_err = overflow_err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed scenarios plus random
// byte streams, compared every cycle against a behavioural session model.
module tb_imem_loader;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BYTE_W = 8;
  localparam int M_IDLE = 0, M_COLL = 1, M_WRITE = 2, M_DONE = 3;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0, finish = 1'b0, byte_valid = 1'b0;
  logic [BYTE_W-1:0] byte_data = '0;
  logic              byte_ready, wr_en, busy, done, partial_err, overflow_err;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data, checksum;
  logic [ADDR_W:0]   word_count;

  imem_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BYTE_W(BYTE_W)) dut (
    .clk(clk), .reset(reset), .start(start), .finish(finish),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .word_count(word_count), .checksum(checksum), .busy(busy), .done(done),
    .partial_err(partial_err), .overflow_err(overflow_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  // Session model: pending bytes in a queue, words packed MSB first.
  int        m_mode = M_IDLE;
  bit [7:0]  bq[$];
  bit [31:0] m_word, m_cks;
  int        m_addr, m_cnt;
  bit        m_perr, m_oerr, m_full, m_fpend;

  function automatic void model_reset();
    m_mode = M_IDLE; bq.delete(); m_word = 0; m_cks = 0; m_addr = 0; m_cnt = 0;
    m_perr = 0; m_oerr = 0; m_full = 0; m_fpend = 0;
  endfunction

  function automatic void model_step(bit st, bit fin, bit v, bit [7:0] d);
    bit last;
    if (st) begin
      m_mode = M_COLL; bq.delete(); m_addr = 0; m_cnt = 0; m_cks = 0;
      m_perr = 0; m_oerr = 0; m_full = 0; m_fpend = 0;
      return;
    end
    case (m_mode)
      M_COLL: begin
        if (m_full) begin
          if (v) begin m_oerr = 1; m_mode = M_DONE; end
          else if (fin) m_mode = M_DONE;
        end else begin
          if (v) bq.push_back(d);
          if (bq.size() == 4) begin
            m_word = {bq[0], bq[1], bq[2], bq[3]};
            bq.delete();
            m_mode = M_WRITE;
            m_fpend = fin;
          end else if (fin) begin
            m_perr = (bq.size() != 0);
            m_mode = M_DONE;
          end
        end
      end
      M_WRITE: begin
        if (m_cnt < 256) m_cnt++;
        m_cks ^= m_word;
        last = (m_addr == 255);
        if (!last) m_addr++;
        if (m_fpend || fin) begin m_mode = M_DONE; m_fpend = 0; end
        else begin m_mode = M_COLL; m_full = last; end
      end
      default: ;
    endcase
  endfunction

  always @(posedge clk) if (!reset) model_step(start, finish, byte_valid, byte_data);

  // Write log from the DUT strobe, used for literal end-of-scenario checks.
  logic [31:0] mem [0:255];
  int          n_writes = 0;
  logic [7:0]  last_wa = '0;
  logic [31:0] last_wd = '0;

  always @(negedge clk) begin
    chk("byte_ready", 64'(byte_ready), 64'((m_mode == M_COLL) && !m_full));
    chk("wr_en", 64'(wr_en), 64'(m_mode == M_WRITE));
    chk("busy", 64'(busy), 64'((m_mode == M_COLL) || (m_mode == M_WRITE)));
    chk("done", 64'(done), 64'(m_mode == M_DONE));
    chk("partial_err", 64'(partial_err), 64'(m_perr));
    chk("overflow_err", 64'(overflow_err), 64'(m_oerr));
    chk("word_count", 64'(word_count), 64'(m_cnt));
    chk("checksum", 64'(checksum), 64'(m_cks));
    if (m_mode == M_WRITE) begin
      chk("wr_addr", 64'(wr_addr), 64'(m_addr));
      chk("wr_data", 64'(wr_data), 64'(m_word));
    end
    if (wr_en === 1'b1) begin
      mem[wr_addr] = wr_data;
      last_wa = wr_addr;
      last_wd = wr_data;
      n_writes++;
    end
  end

  // One cycle of stimulus; called and returns just after a falling edge.
  task automatic cyc(input bit st, input bit fin, input bit v, input bit [7:0] d);
    start = st; finish = fin; byte_valid = v; byte_data = d;
    @(negedge clk); #1;
    start = 0; finish = 0; byte_valid = 0;
  endtask

  // Offer a byte with valid held high until the loader is ready.
  task automatic send_byte(input bit [7:0] d, input bit fin);
    int guard = 0;
    while (!byte_ready && guard < 50) begin
      cyc(0, 0, 1, d);
      guard++;
    end
    if (guard >= 50) chk("byte_ready timeout", 64'(byte_ready), 64'(1));
    cyc(0, fin, 1, d);
  endtask

  task automatic send_word(input bit [31:0] w);
    for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8], 0);
  endtask

  task automatic do_reset();
    reset = 1;
    model_reset();
    #1;
    chk("rst outputs", 64'({byte_ready, wr_en, busy, done, partial_err, overflow_err}), 64'(0));
    chk("rst wr_addr", 64'(wr_addr), 64'(0));
    chk("rst wr_data", 64'(wr_data), 64'(0));
    chk("rst word_count", 64'(word_count), 64'(0));
    chk("rst checksum", 64'(checksum), 64'(0));
    repeat (2) @(negedge clk);
    #1 reset = 0;
  endtask

  int wr_before;
  int r;

  initial begin
    model_reset();
    @(negedge clk); #1;
    do_reset();

    // First word and latency: wr_en sampled the cycle after the 4th byte.
    cyc(1, 0, 0, 0);
    send_word(32'h20080020);
    chk("t1 wr_en next cycle", 64'(wr_en), 64'(1));
    chk("t1 wr_data", 64'(wr_data), 64'h20080020);
    chk("t1 wr_addr", 64'(wr_addr), 64'(0));
    cyc(0, 0, 0, 0);
    chk("t1 count", 64'(word_count), 64'(1));
    chk("t1 checksum", 64'(checksum), 64'h20080020);

    // Two back-to-back words with valid held high.
    cyc(1, 0, 0, 0);
    send_word(32'h20080020);
    send_word(32'h20090037);
    cyc(0, 0, 1, 8'h00);
    chk("t2 last addr", 64'(last_wa), 64'(1));
    chk("t2 checksum", 64'(checksum), 64'h00010017);
    cyc(0, 1, 0, 0);
    chk("t2 done", 64'(done), 64'(1));
    chk("t2 errors", 64'({partial_err, overflow_err}), 64'(0));

    // Finish with two bytes pending.
    cyc(1, 0, 0, 0);
    wr_before = n_writes;
    send_byte(8'h01, 0);
    send_byte(8'h02, 0);
    cyc(0, 1, 0, 0);
    cyc(0, 0, 0, 0);
    chk("t3 no write", 64'(n_writes), 64'(wr_before));
    chk("t3 partial_err", 64'(partial_err), 64'(1));
    chk("t3 done", 64'(done), 64'(1));
    chk("t3 count", 64'(word_count), 64'(0));

    // Fill the whole memory, then overflow.
    cyc(1, 0, 0, 0);
    for (int k = 0; k < 256; k++) send_word(32'(k));
    cyc(0, 0, 0, 0);
    chk("t4 last addr", 64'(last_wa), 64'hFF);
    chk("t4 mem[128]", 64'(mem[128]), 64'd128);
    chk("t4 ready after full", 64'(byte_ready), 64'(0));
    cyc(0, 0, 1, 8'h55);
    chk("t4 overflow_err", 64'(overflow_err), 64'(1));
    chk("t4 count", 64'(word_count), 64'd256);
    chk("t4 checksum", 64'(checksum), 64'h0);
    chk("t4 done", 64'(done), 64'(1));

    // Reset mid-word, then a fresh session restarts at address 0.
    cyc(1, 0, 0, 0);
    for (int k = 0; k < 3; k++) send_word(32'hA0B0C000 + 32'(k));
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    do_reset();
    cyc(1, 0, 0, 0);
    send_word(32'hCAFEF00D);
    chk("t5 wr_addr", 64'(wr_addr), 64'(0));
    cyc(0, 0, 0, 0);
    chk("t5 count", 64'(word_count), 64'(1));

    // Finish together with the 4th byte, then start+finish in DONE.
    cyc(1, 0, 0, 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    send_byte(8'h33, 0);
    send_byte(8'hAA, 1);
    cyc(0, 0, 0, 0);
    chk("t6 write addr", 64'(last_wa), 64'(0));
    chk("t6 write data", 64'(last_wd), 64'h112233AA);
    chk("t6 done", 64'(done), 64'(1));
    chk("t6 partial_err", 64'(partial_err), 64'(0));
    cyc(1, 1, 0, 0);
    chk("t6 restart done", 64'(done), 64'(0));
    chk("t6 restart busy", 64'(busy), 64'(1));

    // Random sessions with gaps, early finishes and restarts.
    for (int s = 0; s < 30; s++) begin
      cyc(1, 0, 0, 0);
      for (int c = 0; c < 60; c++) begin
        r = int'($urandom_range(99, 0));
        if (r >= 97) cyc(1, 0, 0, 0);
        else cyc(0, r < 3, ($urandom_range(3, 0) != 0), 8'($urandom));
      end
    end

    repeat (3) cyc(0, 0, 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Write-side counterpart to the word-addressed instruction memory fetch path.
- Accepts a byte stream (board switches or a host link) over a valid/ready handshake and packs each 4 bytes into one 32-bit word, MSB byte first.
- Issues single-cycle write strobes into instruction memory at auto-incrementing word addresses starting at 0.
- Reports the word count, a running XOR checksum, and the completion and error flags that the board shows on LEDs and HEX displays.

Parameters:
- ADDR_W, 8, word-address width; memory depth is 2**ADDR_W words.
- DATA_W, 32, instruction word width; must equal 4*BYTE_W.
- BYTE_W, 8, input byte width.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a new load session at address 0.
- finish  in  1  one-cycle pulse; ends the session.
- byte_valid  in  1  byte_data holds a valid byte.
- byte_data  in  BYTE_W  input byte.
- byte_ready  out  1  loader accepts byte_data this cycle.
- wr_en  out  1  memory write strobe, one cycle per word.
- wr_addr  out  ADDR_W  word address of the write.
- wr_data  out  DATA_W  assembled word.
- word_count  out  ADDR_W+1  number of words written this session.
- checksum  out  DATA_W  XOR of all words written this session.
- busy  out  1  session active (COLLECT or WRITE).
- done  out  1  session ended; held until the next start.
- partial_err  out  1  finish arrived with 1-3 bytes pending.
- overflow_err  out  1  a write to the last address occurred and further bytes were offered.

Behaviour:
- Reset: async assertion forces IDLE. All outputs are 0: byte_ready, wr_en, wr_addr, wr_data, word_count, checksum, busy, done, both error flags. The byte index and the shift register are also cleared.
- States: IDLE, COLLECT, WRITE, DONE.
- IDLE: byte_ready=0. start moves to COLLECT, clears wr_addr, word_count, checksum, byte index, done and the error flags.
- COLLECT: byte_ready=1, busy=1.
  - A byte is accepted when byte_valid && byte_ready at a rising edge: shreg <= {shreg[23:0], byte_data}, and the index increments.
  - On the 4th accepted byte, move to WRITE.
- WRITE: byte_ready=0, wr_en=1 for exactly one cycle, with wr_addr equal to the current address and wr_data equal to the assembled word.
  - At the following edge: word_count+1, checksum ^= wr_data, byte index cleared.
  - If wr_addr was not the last address, wr_addr+1 and return to COLLECT.
  - If wr_addr was 2**ADDR_W-1, wr_addr stays at that value, the state enters a full condition: COLLECT with byte_ready=0.
  - In the full condition, any byte_valid sets overflow_err and moves to DONE.
- Latency: 4th byte accepted at edge N gives wr_en high in cycle N+1. Peak throughput is one word per 5 cycles.
- finish in COLLECT, index 0: move to DONE, done=1.
- finish in COLLECT, index 1-3: discard the pending bytes, no write, partial_err=1, DONE.
- finish in the same cycle as an accepted byte: the byte is absorbed first.
  - If it completes a word, the loader latches finish_pend, performs the WRITE, then goes to DONE (no error).
  - Otherwise partial_err=1 and DONE.
- finish during WRITE: latch finish_pend, complete the write, go to DONE.
- start in COLLECT, WRITE or DONE: restarts the session (same clearing as IDLE→COLLECT).
  - If start arrives during WRITE, the in-flight write still completes this cycle but is not counted.
  - start beats finish when both arrive in the same cycle.
- DONE: byte_ready=0, busy=0, done=1. word_count, checksum and the error flags are held. finish is ignored.
- Reset mid-session: returns to IDLE immediately. Words already written stay in memory, with no rollback. An active wr_en drops asynchronously.
- word_count saturates at 2**ADDR_W. Checksum is a plain bitwise XOR with no carry.
- wr_data and wr_addr hold their last values outside WRITE.

Decomposition:
- Shared package imem_pkg:
  - ADDR_W, DATA_W and BYTE_W defaults.
  - A BYTES_PER_WORD=4 constant.
  - The loader state encoding: IDLE=0, COLLECT=1, WRITE=2, DONE=3.
- One sub-module, byte_packer: the 2-bit byte index, the 32-bit shift register, a word_full flag and a synchronous clear.
- The FSM, address counter and checksum live in the top level.

Test Plan:
- start; bytes 0x20,0x08,0x00,0x20 → wr_en for one cycle, wr_addr=0, wr_data=0x20080020; word_count=1; checksum=0x20080020; wr_en is high the cycle after the 4th byte.
- Two words 0x20080020, 0x20090037, with byte_valid held high continuously → byte_ready=0 during each WRITE cycle; writes at addr 0 and 1; checksum=0x00010017; finish → done=1, no errors.
- start; bytes 0x01,0x02; finish → no wr_en, partial_err=1, done=1, word_count=0.
- Load 256 words (word k = k), then offer one more byte → last write at addr 0xFF; byte_ready=0 afterwards; overflow_err=1; word_count=256; checksum=0x00000000.
- Reset asserted after 2 bytes of word 3 → all outputs 0 immediately. A new start and a 4-byte word then writes addr 0 with word_count=1.
- finish coincident with a 4th byte 0xAA (word 0x112233AA) → write at addr 0, then DONE with partial_err=0. start and finish coincident in DONE → new session begins, done=0.
